indent_line_framer: RTL and testbench

// - Front stage of the source tokenizer pipeline. Sits directly upstream of the token classifier.
// - Consumes the raw source byte stream and resolves line structure:
//   - measures leading spaces and emits INDENT/DEDENT markers;
//   - drops blank lines and turns '\n' into NEWLINE;
//   - on end of source, appends the implicit final newline, closing DEDENTs and EOF.
// - Body bytes pass through as CHAR items. The classifier downstream only has to handle in-line lexing.

---
 rtl/tok_pkg.sv | 39 +++
 rtl/tok_out_slice.sv | 55 +++++
 rtl/indent_line_framer.sv | 217 +++++++++++++++++++++
 tb/tb_indent_line_framer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tok_pkg.sv
// Shared types and constants for the source tokenizer front end.
// Item kinds travelling from the line framer to the classifier, error codes,
// framer FSM states and the two ASCII bytes that carry line structure.
package tok_pkg;

  // Default geometry of the indentation grid.
  localparam int INDENT_WIDTH = 4;
  localparam int MAX_LEVEL    = 15;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_NL = 8'h0A;

  // Item kinds on the framer output.
  typedef enum logic [2:0] {
    TOK_CHAR    = 3'd0,
    TOK_NEWLINE = 3'd1,
    TOK_INDENT  = 3'd2,
    TOK_DEDENT  = 3'd3,
    TOK_EOF     = 3'd4
  } tok_kind_e;

  // Sticky error causes.
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,  // leading spaces not a multiple of INDENT_WIDTH
    ERR_DEPTH = 2'd2   // indentation deeper than MAX_LEVEL
  } err_code_e;

  // Line framer states.
  typedef enum logic [2:0] {
    ST_BOL  = 3'd0,  // measuring leading spaces
    ST_ADJ  = 3'd1,  // emitting INDENT/DEDENT, then the held first byte
    ST_BODY = 3'd2,  // passing body bytes through
    ST_END  = 3'd3,  // closing NEWLINE, DEDENTs and EOF
    ST_DONE = 3'd4,  // stream finished
    ST_ERR  = 3'd5   // stream rejected
  } state_e;

endpackage

// File: rtl/tok_out_slice.sv
// Purpose : registered output stage holding one item (3-bit kind + 8-bit data).
// Latency : an item pushed in cycle N is presented on out_valid in cycle N+1.
// Backpr. : push_rdy = !out_valid || out_ready; payload held stable while stalled.
// Ports   : clk/rst (sync, active high); push/push_kind/push_data/push_rdy from
//           the producer FSM; out_valid/out_ready/out_kind/out_data downstream.
module tok_out_slice (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [2:0] push_kind,
  input  logic [7:0] push_data,
  output logic       push_rdy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_kind,
  output logic [7:0] out_data
);

  logic       vld_q,  vld_d;
  logic [2:0] kind_q, kind_d;
  logic [7:0] data_q, data_d;

  // The slot is free when empty or when its current item leaves this cycle.
  assign push_rdy = !vld_q || out_ready;

  always_comb begin
    vld_d  = vld_q;
    kind_d = kind_q;
    data_d = data_q;
    if (push && push_rdy) begin
      vld_d  = 1'b1;
      kind_d = push_kind;
      data_d = push_data;
    end else if (out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      kind_q <= 3'd0;
      data_q <= 8'd0;
    end else begin
      vld_q  <= vld_d;
      kind_q <= kind_d;
      data_q <= data_d;
    end
  end

  assign out_valid = vld_q;
  assign out_kind  = kind_q;
  assign out_data  = data_q;

endmodule

// File: rtl/indent_line_framer.sv
// Purpose : resolves line structure of a source byte stream into CHAR, NEWLINE,
//           INDENT, DEDENT and EOF items for the token classifier.
// Latency : an accepted byte that produces an item shows it on out_valid next cycle.
// Backpr. : in_ready only in BOL/BODY with a free output slot; ADJ/END stall on out_ready.
// Ports   : clk, rst (sync, active high); in_valid/in_ready/in_data/in_last source
//           bytes; out_valid/out_ready/out_kind/out_data items; err/err_code sticky.
module indent_line_framer #(
  parameter int INDENT_WIDTH = tok_pkg::INDENT_WIDTH,
  parameter int MAX_LEVEL    = tok_pkg::MAX_LEVEL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_kind,
  output logic [7:0] out_data,
  output logic       err,
  output logic [1:0] err_code
);
  import tok_pkg::*;

  localparam int LVL_W  = $clog2(MAX_LEVEL + 1);
  localparam int SP_MAX = INDENT_WIDTH * MAX_LEVEL;
  localparam int SP_W   = $clog2(SP_MAX + 1);

  state_e           state_q,     state_d;
  logic [LVL_W-1:0] level_q,     level_d;
  logic [LVL_W-1:0] target_q,    target_d;
  logic [SP_W-1:0]  space_cnt_q, space_cnt_d;
  logic [7:0]       held_q,      held_d;      // first body byte parked during ADJ
  logic             last_q,      last_d;      // held byte was the final source byte
  logic             end_nl_q,    end_nl_d;    // END must open with a NEWLINE
  logic             err_q,       err_d;
  err_code_e        err_code_q,  err_code_d;

  logic             push;
  tok_kind_e        push_kind;
  logic [7:0]       push_data;
  logic             push_rdy;
  logic             in_fire;
  logic [SP_W-1:0]  sp_rem;
  logic [SP_W-1:0]  sp_lvl;

  // in_ready is forced low while rst is held so the reset value is 0 even
  // though the FSM already sits in BOL.
  assign in_ready = !rst && (state_q == ST_BOL || state_q == ST_BODY) && push_rdy;
  assign in_fire  = in_valid && in_ready;

  assign sp_rem = space_cnt_q % SP_W'(INDENT_WIDTH);
  assign sp_lvl = space_cnt_q / SP_W'(INDENT_WIDTH);

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    target_d    = target_q;
    space_cnt_d = space_cnt_q;
    held_d      = held_q;
    last_d      = last_q;
    end_nl_d    = end_nl_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    push        = 1'b0;
    push_kind   = TOK_CHAR;
    push_data   = 8'h00;

    unique case (state_q)
      ST_BOL: begin
        if (in_fire) begin
          if (in_data == ASCII_SP) begin
            // Reject on the space that would push past the deepest level.
            if (space_cnt_q == SP_W'(SP_MAX)) begin
              state_d    = ST_ERR;
              err_d      = 1'b1;
              err_code_d = ERR_DEPTH;
            end else begin
              space_cnt_d = space_cnt_q + SP_W'(1);
              if (in_last) begin
                state_d  = ST_END;
                end_nl_d = 1'b0;
              end
            end
          end else if (in_data == ASCII_NL) begin
            // Blank line: forget its spaces, emit nothing.
            space_cnt_d = '0;
            if (in_last) begin
              state_d  = ST_END;
              end_nl_d = 1'b0;
            end
          end else if (sp_rem != '0) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_ALIGN;
          end else begin
            // Any other byte (tabs included) starts the body.
            target_d = LVL_W'(sp_lvl);
            held_d   = in_data;
            last_d   = in_last;
            state_d  = ST_ADJ;
          end
        end
      end

      ST_ADJ: begin
        if (push_rdy) begin
          push = 1'b1;
          if (target_q > level_q) begin
            push_kind = TOK_INDENT;
            level_d   = level_q + LVL_W'(1);
          end else if (target_q < level_q) begin
            push_kind = TOK_DEDENT;
            level_d   = level_q - LVL_W'(1);
          end else begin
            push_kind   = TOK_CHAR;
            push_data   = held_q;
            space_cnt_d = '0;
            if (last_q) begin
              // Source ended mid-line: END supplies the implicit newline.
              state_d  = ST_END;
              end_nl_d = 1'b1;
            end else begin
              state_d  = ST_BODY;
            end
          end
        end
      end

      ST_BODY: begin
        if (in_fire) begin
          push = 1'b1;
          if (in_data == ASCII_NL) begin
            push_kind   = TOK_NEWLINE;
            space_cnt_d = '0;
            if (in_last) begin
              state_d  = ST_END;
              end_nl_d = 1'b0;
            end else begin
              state_d  = ST_BOL;
            end
          end else begin
            push_kind = TOK_CHAR;
            push_data = in_data;
            if (in_last) begin
              state_d  = ST_END;
              end_nl_d = 1'b1;
            end
          end
        end
      end

      ST_END: begin
        if (push_rdy) begin
          push = 1'b1;
          if (end_nl_q) begin
            push_kind = TOK_NEWLINE;
            end_nl_d  = 1'b0;
          end else if (level_q != '0) begin
            push_kind = TOK_DEDENT;
            level_d   = level_q - LVL_W'(1);
          end else begin
            push_kind = TOK_EOF;
            state_d   = ST_DONE;
          end
        end
      end

      // DONE and ERR are terminal; the slice drains any item already in flight.
      ST_DONE: ;
      ST_ERR:  ;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOL;
      level_q     <= '0;
      target_q    <= '0;
      space_cnt_q <= '0;
      held_q      <= 8'h00;
      last_q      <= 1'b0;
      end_nl_q    <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      target_q    <= target_d;
      space_cnt_q <= space_cnt_d;
      held_q      <= held_d;
      last_q      <= last_d;
      end_nl_q    <= end_nl_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  tok_out_slice u_out (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_kind (push_kind),
    .push_data (push_data),
    .push_rdy  (push_rdy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_data  (out_data)
  );

  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_indent_line_framer.sv
// Directed bench for indent_line_framer: byte strings in, item lists out.
// Items are recorded as {kind,data} whenever a transfer is about to happen.
module tb_indent_line_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_kind;
  logic [7:0] out_data;
  logic       err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  logic [10:0] got_q[$];
  logic [10:0] exp_q[$];

  bit          bp_mode = 1'b0;
  bit          force_stall = 1'b0;
  int          stall_cnt = 0;
  int          stall_cycles = 0;
  int          stab_errs = 0;
  logic [10:0] bp_hold = 11'h0;

  indent_line_framer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_data  (out_data),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Downstream: free-running, fully stalled, or 5-cycle stall per INDENT/DEDENT.
  always @(negedge clk) begin
    if (bp_mode && out_valid && (out_kind == 3'd2 || out_kind == 3'd3) && stall_cnt < 5) begin
      if (stall_cnt == 0) bp_hold = {out_kind, out_data};
      else if ({out_kind, out_data} !== bp_hold) stab_errs++;
      stall_cnt++;
      stall_cycles++;
      out_ready = 1'b0;
    end else begin
      if (stall_cnt != 0 && {out_kind, out_data} !== bp_hold) stab_errs++;
      stall_cnt = 0;
      out_ready = !force_stall;
    end
  end

  // Record every item that transfers at the following rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) got_q.push_back({out_kind, out_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic void ex(input logic [2:0] k, input logic [7:0] d);
    exp_q.push_back({k, d});
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic l);
    bit ok = 1'b0;
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    while (!ok && n < 200) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
      n++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout byte %h: in_ready never 1, required 1", b);
    end
  endtask

  task automatic send_str(input string s, input bit last_at_end);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_at_end && (i == s.len() - 1));
  endtask

  task automatic wait_eof(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #3;
      if (got_q.size() > 0 && got_q[got_q.size()-1][10:8] == 3'd4) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_kind !== 3'd0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs in_ready=%b out_valid=%b kind=%0d data=%h, required 0 0 0 00",
               in_ready, out_valid, out_kind, out_data);
    end
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_err err=%b code=%0d, required 0 0", err, err_code);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_simple();
    bit ok;
    do_reset();
    send_str("a\n", 1'b1);
    wait_eof(ok);
    ex(3'd0, 8'h61); ex(3'd1, 8'h00); ex(3'd4, 8'h00);
    checks++;
    if (!ok) begin errors++; $display("FAIL simple_eof no EOF seen, required EOF"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL simple_count got %0d items, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL simple_item%0d got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 11'h7ff, exp_q[i]);
      end
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL simple_err err=%b, required 0", err); end
  endtask

  task automatic test_indent();
    bit ok;
    do_reset();
    send_str("if:\n    y\n", 1'b1);
    wait_eof(ok);
    ex(3'd0, 8'h69); ex(3'd0, 8'h66); ex(3'd0, 8'h3a); ex(3'd1, 8'h00); ex(3'd2, 8'h00);
    ex(3'd0, 8'h79); ex(3'd1, 8'h00); ex(3'd3, 8'h00); ex(3'd4, 8'h00);
    checks++;
    if (!ok) begin errors++; $display("FAIL indent_eof no EOF seen, required EOF"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL indent_count got %0d items, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL indent_item%0d got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 11'h7ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_blank();
    bit ok;
    do_reset();
    send_str("x\n\n   \n", 1'b0);
    send_str("z\n", 1'b1);
    wait_eof(ok);
    ex(3'd0, 8'h78); ex(3'd1, 8'h00); ex(3'd0, 8'h7a); ex(3'd1, 8'h00); ex(3'd4, 8'h00);
    checks++;
    if (!ok) begin errors++; $display("FAIL blank_eof no EOF seen, required EOF"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL blank_count got %0d items, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL blank_item%0d got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 11'h7ff, exp_q[i]);
      end
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL blank_err err=%b, required 0", err); end
  endtask

  // A tab at line start is body text; the unterminated line gets a NEWLINE.
  task automatic test_tab();
    bit ok;
    do_reset();
    send_str("\tq", 1'b1);
    wait_eof(ok);
    ex(3'd0, 8'h09); ex(3'd0, 8'h71); ex(3'd1, 8'h00); ex(3'd4, 8'h00);
    checks++;
    if (!ok) begin errors++; $display("FAIL tab_eof no EOF seen, required EOF"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL tab_count got %0d items, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL tab_item%0d got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 11'h7ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_err_align();
    do_reset();
    send_str("   x", 1'b1);
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1) begin
      errors++; $display("FAIL align_err err=%b code=%0d, required 1 1", err, err_code);
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL align_items got %0d items, required 0", got_q.size()); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL align_ready in_ready=%b, required 0", in_ready); end
  endtask

  // 60 spaces is exactly level 15; the 61st space overflows.
  task automatic test_depth();
    do_reset();
    for (int i = 0; i < 60; i++) send_byte(8'h20, 1'b0);
    #3;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL depth_edge err=%b after 60 spaces, required 0", err); end
    send_byte(8'h20, 1'b0);
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2) begin
      errors++; $display("FAIL depth_err err=%b code=%0d, required 1 2", err, err_code);
    end
    checks++;
    if (got_q.size() != 0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL depth_quiet items=%0d in_ready=%b, required 0 0", got_q.size(), in_ready);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    stall_cycles = 0;
    stab_errs = 0;
    bp_mode = 1'b1;
    send_str("a\n", 1'b0);
    send_str("        b", 1'b1);
    wait_eof(ok);
    bp_mode = 1'b0;
    ex(3'd0, 8'h61); ex(3'd1, 8'h00); ex(3'd2, 8'h00); ex(3'd2, 8'h00); ex(3'd0, 8'h62);
    ex(3'd1, 8'h00); ex(3'd3, 8'h00); ex(3'd3, 8'h00); ex(3'd4, 8'h00);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_eof no EOF seen, required EOF"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count got %0d items, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_item%0d got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 11'h7ff, exp_q[i]);
      end
    end
    checks++;
    if (stall_cycles != 20) begin errors++; $display("FAIL bp_stalls got %0d stall cycles, required 20", stall_cycles); end
    checks++;
    if (stab_errs != 0) begin errors++; $display("FAIL bp_stable payload changed %0d times, required 0", stab_errs); end
  endtask

  task automatic test_rst_mid();
    bit ok;
    do_reset();
    force_stall = 1'b1;
    send_str("            b", 1'b0);      // target level 3, first INDENT stuck
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1 || out_kind !== 3'd2) begin
      errors++; $display("FAIL rstmid_pre out_valid=%b kind=%0d, required 1 2", out_valid, out_kind);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drop out_valid=%b, required 0", out_valid); end
    got_q.delete();
    force_stall = 1'b0;
    send_str("q\n", 1'b1);
    wait_eof(ok);
    ex(3'd0, 8'h71); ex(3'd1, 8'h00); ex(3'd4, 8'h00);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_eof no EOF seen, required EOF"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_count got %0d items, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_item%0d got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 11'h7ff, exp_q[i]);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    test_reset();
    test_simple();
    test_indent();
    test_blank();
    test_tab();
    test_err_align();
    test_depth();
    test_backpressure();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
